// File: rtl/nird_riu2_encoder.sv
// Rotation-invariant uniform LBP (riu2) encoder: a 2-stage per-channel datapath
// plus a frame-tracking FSM that counts pixels and flags protocol errors.
module nird_riu2_encoder #(
  parameter int P    = 8,
  parameter int CH   = 2,
  parameter int COLS = 30,
  parameter int ROWS = 30,
  parameter int MODE = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                done_i,
  input  logic                                progress_done_i,
  input  logic [CH*P-1:0]                     bits_i,
  output logic [CH*P-1:0]                     data_o,
  output logic                                done_o,
  output logic                                progress_done_o,
  output logic [$clog2(COLS*ROWS+1)-1:0]      pix_cnt_o,
  output logic                                err_o
);

  localparam int UW        = $clog2(P + 1);
  localparam int CW        = $clog2(COLS * ROWS + 1);
  localparam int TOTAL     = COLS * ROWS;
  localparam int NONUNI    = P + 1;
  localparam int MODE_RIU2 = 0;
  localparam int MODE_RAW  = 1;
  localparam int MODE_UNI  = 2;

  localparam logic [CW-1:0] TOTAL_C   = TOTAL[CW-1:0];
  localparam logic [P-1:0]  NONUNI_C  = NONUNI[P-1:0];
  localparam logic [UW-1:0] U_LIMIT   = UW'(2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Circular 0/1 transitions: compare every bit with its right-rotated neighbour.
  function automatic logic [UW-1:0] trans_count(input logic [P-1:0] pat);
    logic [P-1:0]  rot;
    logic [UW-1:0] n;
    rot = {pat[0], pat[P-1:1]};
    n   = '0;
    for (int k = 0; k < P; k++) begin
      n = n + UW'(pat[k] ^ rot[k]);
    end
    return n;
  endfunction

  function automatic logic [UW-1:0] pop_count(input logic [P-1:0] pat);
    logic [UW-1:0] n;
    n = '0;
    for (int k = 0; k < P; k++) begin
      n = n + UW'(pat[k]);
    end
    return n;
  endfunction

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic                    flush_cnt_r;
  logic                    flush_nxt_s;
  logic                    accept_s;
  logic                    cnt_full_s;
  logic                    reach_s;
  logic [CW-1:0]           cnt_inc_s;
  logic [CW-1:0]           cnt_nxt_s;
  logic                    pulse_nxt_s;
  logic                    err_nxt_s;

  logic [CH-1:0][UW-1:0]   trans_s;
  logic [CH-1:0][UW-1:0]   ones_s;
  logic [CH-1:0][UW-1:0]   trans_r;
  logic [CH-1:0][UW-1:0]   ones_r;
  logic [CH*P-1:0]         raw_r;
  logic                    valid_r;
  logic [CH*P-1:0]         code_s;

  // Pixels arriving while the pipeline drains are rejected (and flagged below).
  assign accept_s   = done_i && (state_r != FLUSH);
  assign cnt_full_s = (pix_cnt_o == TOTAL_C);
  assign cnt_inc_s  = cnt_full_s ? pix_cnt_o : pix_cnt_o + CW'(1);
  assign reach_s    = (cnt_inc_s == TOTAL_C);

  // Stage-1 features: per-channel transition count and popcount.
  always_comb begin
    trans_s = '0;
    ones_s  = '0;
    for (int c = 0; c < CH; c++) begin
      trans_s[c] = trans_count(bits_i[c*P +: P]);
      ones_s[c]  = pop_count(bits_i[c*P +: P]);
    end
  end

  // Stage-1 pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      trans_r <= '0;
      ones_r  <= '0;
      raw_r   <= '0;
    end else begin
      valid_r <= accept_s;
      if (accept_s) begin
        trans_r <= trans_s;
        ones_r  <= ones_s;
        raw_r   <= bits_i;
      end
    end
  end

  // Stage-2 code selection from the registered features.
  always_comb begin
    code_s = '0;
    for (int c = 0; c < CH; c++) begin
      case (MODE)
        MODE_RIU2: begin
          if (trans_r[c] <= U_LIMIT) begin
            code_s[c*P +: P] = {{(P-UW){1'b0}}, ones_r[c]};
          end else begin
            code_s[c*P +: P] = NONUNI_C;
          end
        end
        MODE_RAW: code_s[c*P +: P] = raw_r[c*P +: P];
        MODE_UNI: begin
          if (trans_r[c] <= U_LIMIT) begin
            code_s[c*P +: P] = {{(P-UW){1'b0}}, ones_r[c]};
          end else begin
            code_s[c*P +: P] = '0;
          end
        end
        default: code_s[c*P +: P] = '0;
      endcase
    end
  end

  // Stage-2 output register; data_o holds between valid words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_o <= 1'b0;
      data_o <= '0;
    end else begin
      done_o <= valid_r;
      if (valid_r) begin
        data_o <= code_s;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; a frame ends on a full count or an upstream end-of-frame.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (done_i) begin
          state_nxt_s = reach_s ? FLUSH : RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if ((done_i && reach_s) || progress_done_i) begin
          state_nxt_s = FLUSH;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FLUSH: begin
        if (flush_cnt_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = FLUSH;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output logic: next values of the registered frame outputs.
  always_comb begin
    cnt_nxt_s   = pix_cnt_o;
    pulse_nxt_s = 1'b0;
    flush_nxt_s = 1'b0;
    err_nxt_s   = err_o;
    case (state_r)
      IDLE, RUN: begin
        if (accept_s) begin
          cnt_nxt_s = cnt_inc_s;
        end else begin
          cnt_nxt_s = pix_cnt_o;
        end
      end
      FLUSH: begin
        flush_nxt_s = ~flush_cnt_r;
        if (done_i) begin
          err_nxt_s = 1'b1;
        end else begin
          err_nxt_s = err_o;
        end
        if (flush_cnt_r) begin
          pulse_nxt_s = 1'b1;
          cnt_nxt_s   = '0;
        end else begin
          pulse_nxt_s = 1'b0;
        end
      end
      default: begin
        cnt_nxt_s   = '0;
        flush_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered frame outputs and flush-phase counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt_r     <= 1'b0;
      progress_done_o <= 1'b0;
      pix_cnt_o       <= '0;
      err_o           <= 1'b0;
    end else begin
      flush_cnt_r     <= flush_nxt_s;
      progress_done_o <= pulse_nxt_s;
      pix_cnt_o       <= cnt_nxt_s;
      err_o           <= err_nxt_s;
    end
  end

endmodule

// File: tb/tb_nird_riu2_encoder.sv
// Bench: code vectors on P=8/P=16 encoders (all modes) and frame-control
// sequences on a 4x2 frame instance, checked through expectation queues.
module tb_nird_riu2_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Group A: P=8 riu2 plus P=16 in modes 0/1/2, default 30x30 frame.
  logic        a_done, a_prog;
  logic [15:0] a_bits8;
  logic [31:0] a_bits16;
  logic [15:0] a8_data;
  logic        a8_done, a8_pd, a8_err;
  logic [9:0]  a8_cnt;
  logic [31:0] a16_data [3];
  logic        a16_done [3];
  logic        a16_pd   [3];
  logic        a16_err  [3];
  logic [9:0]  a16_cnt  [3];

  nird_riu2_encoder #(.P(8), .CH(2), .MODE(0)) u_a8 (
    .clk(clk), .rst(rst), .done_i(a_done), .progress_done_i(a_prog), .bits_i(a_bits8),
    .data_o(a8_data), .done_o(a8_done), .progress_done_o(a8_pd), .pix_cnt_o(a8_cnt), .err_o(a8_err));

  for (genvar g = 0; g < 3; g++) begin : g16
    nird_riu2_encoder #(.P(16), .CH(2), .MODE(g)) u_a16 (
      .clk(clk), .rst(rst), .done_i(a_done), .progress_done_i(a_prog), .bits_i(a_bits16),
      .data_o(a16_data[g]), .done_o(a16_done[g]), .progress_done_o(a16_pd[g]),
      .pix_cnt_o(a16_cnt[g]), .err_o(a16_err[g]));
  end

  // Group B: 4x2 frame for control sequences.
  logic        b_done, b_prog;
  logic [15:0] b_bits;
  logic [15:0] b_data;
  logic        b_done_o, b_pd, b_err;
  logic [3:0]  b_cnt;

  nird_riu2_encoder #(.P(8), .CH(2), .COLS(4), .ROWS(2), .MODE(0)) u_b (
    .clk(clk), .rst(rst), .done_i(b_done), .progress_done_i(b_prog), .bits_i(b_bits),
    .data_o(b_data), .done_o(b_done_o), .progress_done_o(b_pd), .pix_cnt_o(b_cnt), .err_o(b_err));

  typedef struct {logic [15:0] d8; logic [31:0] m0, m1, m2; int cyc;} a_exp_t;
  typedef struct {logic [15:0] d; int cyc;} b_exp_t;
  typedef struct {logic [15:0] in8; logic [31:0] in16; logic [15:0] ex8; logic [31:0] ex0, ex1, ex2;} vec_t;

  a_exp_t aq[$];
  b_exp_t bq[$];
  vec_t   vt[15];

  logic [15:0] a_last = 16'h0;
  int b_dcnt = 0, b_pcnt = 0, b_last_done_cyc = 0, b_pd_cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference code: transitions counted against a left rotation with $countones.
  function automatic logic [15:0] model(input logic [15:0] b, input int p, input int mode);
    int u, pc;
    if (p == 8) begin
      u  = $countones(b[7:0] ^ {b[6:0], b[7]});
      pc = $countones(b[7:0]);
    end else begin
      u  = $countones(b ^ {b[14:0], b[15]});
      pc = $countones(b);
    end
    if (mode == 1) return b;
    if (u <= 2) return 16'(pc);
    return (mode == 0) ? 16'(p + 1) : 16'h0;
  endfunction

  function automatic logic [31:0] exp_lanes(input logic [31:0] in, input int p, input int mode);
    logic [15:0] r0, r1;
    if (p == 8) begin
      r0 = model({8'h0, in[7:0]}, 8, mode);
      r1 = model({8'h0, in[15:8]}, 8, mode);
      return {16'h0, r1[7:0], r0[7:0]};
    end
    r0 = model(in[15:0], 16, mode);
    r1 = model(in[31:16], 16, mode);
    return {r1, r0};
  endfunction

  // Group A scoreboard: every done_o pops one expectation, checked 2 cycles after issue.
  always @(negedge clk) begin
    if (!rst) begin
      if (a8_done) begin
        if (aq.size() == 0) begin
          chk("a_unexpected_done", a8_done, 1'b0);
        end else begin
          a_exp_t e;
          e = aq.pop_front();
          chk("a_latency", 64'(cyc - e.cyc), 64'd2);
          chk("a8_data", a8_data, e.d8);
          chk("a16_m0_data", a16_data[0], e.m0);
          chk("a16_m1_data", a16_data[1], e.m1);
          chk("a16_m2_data", a16_data[2], e.m2);
          chk("a16_done_align", {a16_done[0], a16_done[1], a16_done[2]}, 3'b111);
        end
      end else begin
        chk("a8_hold", a8_data, a_last);
        if (aq.size() > 0 && cyc > aq[0].cyc + 2) begin
          chk("a_done_missing", a8_done, 1'b1);
          void'(aq.pop_front());
        end
      end
    end
    a_last <= a8_data;
  end

  // Group B scoreboard and frame-event bookkeeping.
  always @(negedge clk) begin
    if (!rst) begin
      if (b_done_o) begin
        b_dcnt          <= b_dcnt + 1;
        b_last_done_cyc <= cyc;
        if (bq.size() == 0) begin
          chk("b_unexpected_done", b_done_o, 1'b0);
        end else begin
          b_exp_t e;
          e = bq.pop_front();
          chk("b_latency", 64'(cyc - e.cyc), 64'd2);
          chk("b_data", b_data, e.d);
        end
      end else if (bq.size() > 0 && cyc > bq[0].cyc + 2) begin
        chk("b_done_missing", b_done_o, 1'b1);
        void'(bq.pop_front());
      end
      if (b_pd) begin
        b_pcnt   <= b_pcnt + 1;
        b_pd_cyc <= cyc;
      end
    end
  end

  task automatic b_drive(input logic d, input logic p, input logic push);
    logic [15:0] bits;
    logic [31:0] e;
    bits = 16'($urandom);
    @(posedge clk); #1;
    b_done = d; b_prog = p; b_bits = bits;
    if (push) begin
      e = exp_lanes({16'h0, bits}, 8, 0);
      bq.push_back('{e[15:0], cyc});
    end
  endtask

  task automatic b_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      b_done = 1'b0; b_prog = 1'b0;
    end
  endtask

  task automatic frame_check(input string nm, input int d0, input int p0, input int nd, input logic e_err);
    chk({nm, "_done_count"}, 64'(b_dcnt - d0), 64'(nd));
    chk({nm, "_pulse_count"}, 64'(b_pcnt - p0), 64'd1);
    chk({nm, "_pulse_after_last"}, 64'(b_pd_cyc - b_last_done_cyc), 64'd1);
    chk({nm, "_cnt_cleared"}, b_cnt, 4'd0);
    chk({nm, "_err"}, b_err, e_err);
  endtask

  initial begin
    int d0, p0;
    logic [7:0]  p8  [5] = '{8'h00, 8'hFF, 8'h0F, 8'h55, 8'h81};
    logic [7:0]  e8  [5] = '{8'd0, 8'd8, 8'd4, 8'd9, 8'd2};
    logic [15:0] p16 [5] = '{16'h00F0, 16'h0101, 16'hFFFF, 16'h0000, 16'h8001};
    logic [15:0] e0  [5] = '{16'd4, 16'd17, 16'd16, 16'd0, 16'd2};
    logic [15:0] e2  [5] = '{16'd4, 16'd0, 16'd16, 16'd0, 16'd2};

    for (int i = 0; i < 5; i++) begin
      vt[i].in8  = {p8[i], p8[i]};
      vt[i].ex8  = {e8[i], e8[i]};
      vt[i].in16 = {p16[i], p16[i]};
      vt[i].ex0  = {e0[i], e0[i]};
      vt[i].ex1  = {p16[i], p16[i]};
      vt[i].ex2  = {e2[i], e2[i]};
    end
    for (int i = 5; i < 15; i++) begin
      vt[i].in8  = 16'($urandom);
      vt[i].in16 = $urandom;
      vt[i].ex8  = 16'(exp_lanes({16'h0, vt[i].in8}, 8, 0));
      vt[i].ex0  = exp_lanes(vt[i].in16, 16, 0);
      vt[i].ex1  = exp_lanes(vt[i].in16, 16, 1);
      vt[i].ex2  = exp_lanes(vt[i].in16, 16, 2);
    end

    rst = 1'b1;
    a_done = 1'b0; a_prog = 1'b0; a_bits8 = 16'h0; a_bits16 = 32'h0;
    b_done = 1'b0; b_prog = 1'b0; b_bits = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_a8_outputs", {a8_data, a8_done, a8_pd, a8_cnt, a8_err}, 64'd0);
    for (int g = 0; g < 3; g++)
      chk("rst_a16_outputs", {a16_data[g], a16_done[g], a16_pd[g], a16_cnt[g], a16_err[g]}, 64'd0);
    chk("rst_b_outputs", {b_data, b_done_o, b_pd, b_cnt, b_err}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Code vectors: first ten back-to-back, the rest separated by idle cycles.
    for (int i = 0; i < 15; i++) begin
      if (i >= 10) begin
        @(posedge clk); #1;
        a_done = 1'b0;
      end
      @(posedge clk); #1;
      a_done = 1'b1; a_bits8 = vt[i].in8; a_bits16 = vt[i].in16;
      aq.push_back('{vt[i].ex8, vt[i].ex0, vt[i].ex1, vt[i].ex2, cyc});
    end
    @(posedge clk); #1;
    a_done = 1'b0;
    repeat (5) @(negedge clk);
    chk("a_queue_drained", 64'(aq.size()), 64'd0);
    chk("a8_pix_cnt", a8_cnt, 10'd15);
    chk("a8_err", a8_err, 1'b0);

    // Full frame of 8 back-to-back pixels.
    d0 = b_dcnt; p0 = b_pcnt;
    for (int i = 0; i < 8; i++) b_drive(1'b1, 1'b0, 1'b1);
    b_idle(1);
    @(negedge clk);
    chk("full_cnt_at_8", b_cnt, 4'd8);
    repeat (5) @(negedge clk);
    frame_check("full", d0, p0, 8, 1'b0);

    // progress_done_i in IDLE is ignored.
    p0 = b_pcnt;
    b_drive(1'b0, 1'b1, 1'b0);
    b_idle(1);
    repeat (4) @(negedge clk);
    chk("idle_prog_no_pulse", 64'(b_pcnt - p0), 64'd0);
    chk("idle_prog_no_err", b_err, 1'b0);

    // Short frame: progress_done_i together with the 5th pixel.
    d0 = b_dcnt; p0 = b_pcnt;
    for (int i = 0; i < 4; i++) b_drive(1'b1, 1'b0, 1'b1);
    b_drive(1'b1, 1'b1, 1'b1);
    b_idle(1);
    @(negedge clk);
    chk("short_cnt_at_5", b_cnt, 4'd5);
    repeat (5) @(negedge clk);
    frame_check("short", d0, p0, 5, 1'b0);

    // Full frame then a done_i landing in the first FLUSH cycle.
    d0 = b_dcnt; p0 = b_pcnt;
    for (int i = 0; i < 8; i++) b_drive(1'b1, 1'b0, 1'b1);
    b_drive(1'b1, 1'b0, 1'b0);
    b_idle(1);
    repeat (5) @(negedge clk);
    frame_check("flush_done", d0, p0, 8, 1'b1);

    // Next frame still works and err_o stays high.
    d0 = b_dcnt; p0 = b_pcnt;
    for (int i = 0; i < 8; i++) b_drive(1'b1, 1'b0, 1'b1);
    b_idle(1);
    repeat (5) @(negedge clk);
    frame_check("after_err", d0, p0, 8, 1'b1);

    // Reset after the 3rd pixel discards everything in flight.
    for (int i = 0; i < 3; i++) b_drive(1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    b_done = 1'b0;
    rst = 1'b1;
    bq.delete();
    @(negedge clk);
    chk("midrst_b_outputs", {b_data, b_done_o, b_pd, b_cnt, b_err}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    d0 = b_dcnt; p0 = b_pcnt;
    repeat (4) @(negedge clk);
    chk("midrst_no_stale_done", 64'(b_dcnt - d0), 64'd0);
    chk("midrst_no_stale_pulse", 64'(b_pcnt - p0), 64'd0);
    for (int i = 0; i < 8; i++) b_drive(1'b1, 1'b0, 1'b1);
    b_idle(1);
    repeat (5) @(negedge clk);
    frame_check("post_rst", d0, p0, 8, 1'b0);
    chk("b_queue_drained", 64'(bq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nird_riu2_encoder.md
NIRD_RIU2_ENCODER -- requirements
Module: nird_riu2_encoder

Interface
REQ-001 Parameter P, default 8: neighbour count per pattern; legal values 8 and 16.
REQ-002 Parameter CH, default 2: number of independent channels, e.g. NI and RD.
REQ-003 Parameter COLS, default 30: frame width in pixels.
REQ-004 Parameter ROWS, default 30: frame height in pixels.
REQ-005 Parameter MODE, default 0: output mode; 0 = riu2, 1 = raw pattern pass-through, 2 = uniform-only (popcount if uniform, else 0).
REQ-006 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-007 Port rst, input, 1: asynchronous, active-high reset.
REQ-008 Port done_i, input, 1: the bits_i word is valid this cycle.
REQ-009 Port progress_done_i, input, 1: upstream end-of-frame pulse.
REQ-010 Port bits_i, input, CH*P: channel c occupies bits [c*P+P-1 : c*P]; bit k is neighbour k+1.
REQ-011 Port data_o, output, CH*P: per-channel code, same lane layout as bits_i, codes zero-extended.
REQ-012 Port done_o, output, 1: data_o is valid this cycle.
REQ-013 Port progress_done_o, output, 1: one-cycle end-of-frame pulse.
REQ-014 Port pix_cnt_o, output, clog2(COLS*ROWS+1): number of pixels accepted in the current frame.
REQ-015 Port err_o, output, 1: sticky protocol-error flag.

Function
REQ-016 The circular transition count of each channel SHALL be U = number of k in 0..P-1 where bit k differs from bit (k+1) mod P.
REQ-017 MODE 0: the code SHALL be popcount(pattern) if U <= 2, else P+1 (P=8 gives the range 0..9).
REQ-018 MODE 1: the code SHALL equal the input pattern. MODE 2: the code SHALL be popcount if U <= 2, else 0.
REQ-019 The datapath SHALL be a 2-stage pipeline:
- stage 1 registers U and popcount per channel (plus the raw pattern);
- stage 2 registers the selected code.
- done_i to done_o latency is exactly 2 cycles.
- Back-to-back done_i SHALL give back-to-back done_o with no bubbles.
REQ-020 data_o SHALL hold its last value while done_o = 0.
REQ-021 The control FSM SHALL have states IDLE, RUN, FLUSH.
REQ-022 IDLE: the first done_i SHALL be accepted and counted, and the FSM SHALL go to RUN.
REQ-023 RUN: each done_i SHALL increment pix_cnt_o. The FSM SHALL go to FLUSH when either of these happens:
- the count reaches COLS*ROWS, including the accepting cycle;
- progress_done_i = 1.
REQ-024 If progress_done_i coincides with a final done_i, that pixel SHALL be accepted and counted before the FSM enters FLUSH.
REQ-025 FLUSH SHALL last exactly 2 cycles to drain the pipeline. On its last cycle, progress_done_o SHALL pulse high for 1 cycle, pix_cnt_o SHALL clear to 0, and the FSM SHALL return to IDLE.
REQ-026 progress_done_o SHALL therefore assert 1 cycle after the done_o of the final pixel when the input runs back-to-back.
REQ-027 done_i during FLUSH SHALL NOT be counted or output, and SHALL set err_o.
REQ-028 progress_done_i in IDLE SHALL be ignored: no pulse, no error.
REQ-029 In RUN, progress_done_i with fewer than COLS*ROWS pixels SHALL still end the frame normally (short frame) and SHALL NOT set err_o.
REQ-030 pix_cnt_o SHALL saturate at COLS*ROWS and never wrap.
REQ-031 err_o SHALL stay high until rst.

Reset
REQ-032 While rst = 1, the FSM SHALL be in IDLE and these outputs SHALL be 0: data_o, done_o, progress_done_o, pix_cnt_o, err_o. All pipeline valid bits SHALL also be 0.
REQ-033 rst asserted mid-frame SHALL discard in-flight pixels: no done_o or progress_done_o after release until new done_i input arrives.
REQ-034 Deassertion of rst SHALL take effect at the next clk edge; the first done_i after release is valid.

Verification
REQ-035 P=8, MODE 0, CH=2, patterns 0x00, 0xFF, 0x0F, 0x55, 0x81 -> codes 0, 8, 4, 9, 2, each 2 cycles after done_i, identical on both lanes.
REQ-036 P=16, MODE 0, pattern 0x00F0 -> 4; pattern 0x0101 -> 17. MODE 1, pattern 0x0101 -> 0x0101. MODE 2, pattern 0x0101 -> 0.
REQ-037 COLS=4, ROWS=2, 8 back-to-back done_i -> 8 done_o pulses, pix_cnt_o reaches 8, then progress_done_o pulses 1 cycle after the last done_o, then pix_cnt_o = 0.
REQ-038 COLS=4, ROWS=2, 5 pixels, then progress_done_i with the 5th -> 5 done_o, then 1 progress_done_o, err_o = 0.
REQ-039 done_i in the FLUSH cycle after a full frame -> no extra done_o, err_o = 1 and held; the next frame still processes normally.
REQ-040 rst pulse after the 3rd of 8 pixels -> all outputs 0 immediately; no stale done_o; a following full frame gives 8 done_o and 1 progress_done_o.
